// File: rtl/rv32_muldiv_if.sv
// Request/result bundle between the RV32I core and the iterative mul/div unit.
// The core drives the request and result_ready; the unit drives handshake status and rd.
interface rv32_muldiv_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_funct3;
  logic [31:0] op_rs1;
  logic [31:0] op_rs2;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        result_illegal;
  logic        busy;

  modport master (
    output op_valid, op_funct3, op_rs1, op_rs2, flush, result_ready,
    input  op_ready, result_valid, result, result_illegal, busy
  );

  modport slave (
    input  op_valid, op_funct3, op_rs1, op_rs2, flush, result_ready,
    output op_ready, result_valid, result, result_illegal, busy
  );
endinterface

// File: rtl/rv32_muldiv.sv
// Iterative RV32M unit: 32/BITS_PER_CYCLE iterations plus the accept cycle; div-by-zero, overflow and disabled ops finish in one.
// Backpressure: the result is held in DONE until result_ready; op_ready is low from accept until the DONE handshake.
module rv32_muldiv #(
  parameter bit ENABLE_MUL     = 1'b1,
  parameter bit ENABLE_DIV     = 1'b1,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic      clk,
  input  logic      reset,
  rv32_muldiv_if.slave md
);
  localparam int         N        = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0] hi_q, lo_q, opnd_q, res_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic        neg_res_q, neg_rem_q, ill_q;

  logic        accept, is_div, enabled, s1, s2, a_neg, b_neg, div0, ovf, special;
  logic [31:0] a_mag, b_mag, spec_res;
  logic [31:0] h_nx, l_nx, q_s, r_s, fin_res;
  logic [32:0] sum, trial;
  logic [63:0] prod, prod_s;

  assign accept = md.op_valid && (state_q == IDLE) && !md.flush;

  // Operand prep and one-cycle special cases, evaluated on the incoming request
  always_comb begin
    is_div   = md.op_funct3[2];
    enabled  = is_div ? ENABLE_DIV : ENABLE_MUL;
    s1       = (md.op_funct3 == 3'b001) || (md.op_funct3 == 3'b010) ||
               (md.op_funct3 == 3'b100) || (md.op_funct3 == 3'b110);
    s2       = (md.op_funct3 == 3'b001) || (md.op_funct3 == 3'b100) ||
               (md.op_funct3 == 3'b110);
    a_neg    = s1 && md.op_rs1[31];
    b_neg    = s2 && md.op_rs2[31];
    a_mag    = a_neg ? -md.op_rs1 : md.op_rs1;
    b_mag    = b_neg ? -md.op_rs2 : md.op_rs2;
    div0     = is_div && (md.op_rs2 == 32'd0);
    ovf      = is_div && !md.op_funct3[0] &&
               (md.op_rs1 == 32'h8000_0000) && (md.op_rs2 == 32'hFFFF_FFFF);
    special  = !enabled || div0 || ovf;
    spec_res = 32'd0;
    if (enabled && div0)
      spec_res = md.op_funct3[1] ? md.op_rs1 : 32'hFFFF_FFFF;
    else if (enabled && ovf)
      spec_res = md.op_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // hi/lo hold accumulator/multiplier for multiply, remainder/quotient for divide
  always_comb begin
    h_nx  = hi_q;
    l_nx  = lo_q;
    sum   = '0;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (f3_q[2]) begin
        trial = {h_nx, l_nx[31]};
        l_nx  = {l_nx[30:0], 1'b0};
        if (trial >= {1'b0, opnd_q}) begin
          h_nx    = 32'(trial - {1'b0, opnd_q});
          l_nx[0] = 1'b1;
        end else begin
          h_nx = trial[31:0];
        end
      end else begin
        sum  = {1'b0, h_nx} + (l_nx[0] ? {1'b0, opnd_q} : 33'd0);
        h_nx = sum[32:1];
        l_nx = {sum[0], l_nx[31:1]};
      end
    end
    prod    = {h_nx, l_nx};
    prod_s  = neg_res_q ? -prod : prod;
    q_s     = neg_res_q ? -l_nx : l_nx;
    r_s     = neg_rem_q ? -h_nx : h_nx;
    fin_res = f3_q[2] ? (f3_q[1] ? r_s : q_s)
                      : ((f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == 5'd0) state_d = DONE;
      DONE:    if (md.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ill_q     <= 1'b0;
    end else if (accept) begin
      f3_q      <= md.op_funct3;
      hi_q      <= '0;
      lo_q      <= a_mag;
      opnd_q    <= b_mag;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      cnt_q     <= CNT_INIT;
      res_q     <= spec_res;
      ill_q     <= !enabled;
    end else if (state_q == CALC && !md.flush) begin
      hi_q <= h_nx;
      lo_q <= l_nx;
      if (cnt_q == 5'd0) res_q <= fin_res;
      else               cnt_q <= cnt_q - 5'd1;
    end
  end

  assign md.op_ready       = (state_q == IDLE);
  assign md.busy           = (state_q != IDLE);
  assign md.result_valid   = (state_q == DONE);
  assign md.result         = (state_q == DONE) ? res_q : 32'd0;
  assign md.result_illegal = (state_q == DONE) && ill_q;
endmodule

// File: tb/tb_rv32_muldiv.sv
// Directed and randomized checks of rv32_muldiv against an arithmetic reference model.
// dut_a: full unit, radix 1; dut_b: divide disabled, radix 4.
module tb_rv32_muldiv;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv32_muldiv_if ifa ();
  rv32_muldiv_if ifb ();

  rv32_muldiv #(.ENABLE_MUL(1'b1), .ENABLE_DIV(1'b1), .BITS_PER_CYCLE(1))
    dut_a (.clk(clk), .reset(reset), .md(ifa));
  rv32_muldiv #(.ENABLE_MUL(1'b1), .ENABLE_DIV(1'b0), .BITS_PER_CYCLE(4))
    dut_b (.clk(clk), .reset(reset), .md(ifb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input int d, input bit v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit fl, input bit rr);
    if (d == 0) begin
      ifa.op_valid = v; ifa.op_funct3 = f3; ifa.op_rs1 = a; ifa.op_rs2 = b;
      ifa.flush = fl; ifa.result_ready = rr;
    end else begin
      ifb.op_valid = v; ifb.op_funct3 = f3; ifb.op_rs1 = a; ifb.op_rs2 = b;
      ifb.flush = fl; ifb.result_ready = rr;
    end
  endtask

  function automatic logic out_valid(input int d);
    return (d == 0) ? ifa.result_valid : ifb.result_valid;
  endfunction

  // Latency counts the accept edge as cycle 1; operands are scrambled right after accept.
  task automatic do_op(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit ack, output logic [31:0] r, output logic il, output int lat);
    @(negedge clk);
    drive(d, 1'b1, f3, a, b, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(d, 1'b0, 3'($urandom), $urandom, $urandom, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid(d) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = (d == 0) ? ifa.result : ifb.result;
    il = (d == 0) ? ifa.result_illegal : ifb.result_illegal;
    if (ack) begin
      @(negedge clk);
      drive(d, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(d, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] r, a, b, exp;
    logic [2:0]  f3;
    logic        il, seen, spc;
    int          lat;

    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_op_ready", 64'(ifa.op_ready), 64'd1);
    chk("reset_busy", 64'(ifa.busy), 64'd0);
    chk("reset_valid", 64'(ifa.result_valid), 64'd0);
    chk("reset_result", 64'(ifa.result), 64'd0);
    chk("reset_illegal", 64'(ifa.result_illegal), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 1, r, il, lat);
    chk("mul_7x-3", 64'(r), 64'hFFFF_FFEB);
    chk("mul_latency", 64'(lat), 64'd33);
    chk("mul_illegal", 64'(il), 64'd0);
    chk("mul_back_idle", 64'(ifa.op_ready), 64'd1);

    do_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 1, r, il, lat);
    chk("mulh_min", 64'(r), 64'h4000_0000);
    do_op(0, 3'd3, 32'h8000_0000, 32'h8000_0000, 1, r, il, lat);
    chk("mulhu_min", 64'(r), 64'h4000_0000);
    do_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, r, il, lat);
    chk("mulhsu_m1", 64'(r), 64'hFFFF_FFFF);

    do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 1, r, il, lat);
    chk("div_-7_2", 64'(r), 64'hFFFF_FFFD);
    chk("div_latency", 64'(lat), 64'd33);
    do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 1, r, il, lat);
    chk("rem_-7_2", 64'(r), 64'hFFFF_FFFF);

    do_op(0, 3'd5, 32'd100, 32'd0, 1, r, il, lat);
    chk("divu_by0", 64'(r), 64'hFFFF_FFFF);
    chk("divu_by0_lat", 64'(lat), 64'd1);
    do_op(0, 3'd7, 32'd100, 32'd0, 1, r, il, lat);
    chk("remu_by0", 64'(r), 64'd100);
    chk("remu_by0_lat", 64'(lat), 64'd1);

    do_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, r, il, lat);
    chk("div_ovf", 64'(r), 64'h8000_0000);
    chk("div_ovf_lat", 64'(lat), 64'd1);
    do_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, r, il, lat);
    chk("rem_ovf", 64'(r), 64'd0);
    chk("rem_ovf_lat", 64'(lat), 64'd1);

    // Backpressure: result held and no new accept while result_ready is low
    do_op(0, 3'd0, 32'd12345, 32'd678, 0, r, il, lat);
    chk("bp_result", 64'(r), 64'd8369910);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", 64'(ifa.result), 64'd8369910);
      chk("bp_op_ready", 64'(ifa.op_ready), 64'd0);
    end
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(ifa.op_ready), 64'd1);
    chk("bp_release_valid", 64'(ifa.result_valid), 64'd0);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Flush at the fifth iteration, with a request held up alongside it
    @(negedge clk);
    drive(0, 1'b1, 3'd0, 32'd3, 32'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 3'd0, 32'd9, 32'd9, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("flush_idle", 64'(ifa.op_ready), 64'd1);
    chk("flush_busy", 64'(ifa.busy), 64'd0);
    @(posedge clk); #1;
    chk("flush_no_accept", 64'(ifa.busy), 64'd0);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= ifa.result_valid;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    drive(0, 1'b1, 3'd4, 32'd1000, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_op_ready", 64'(ifa.op_ready), 64'd1);
    chk("arst_busy", 64'(ifa.busy), 64'd0);
    chk("arst_valid", 64'(ifa.result_valid), 64'd0);
    chk("arst_result", 64'(ifa.result), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(1, 3'd4, 32'd50, 32'd5, 1, r, il, lat);
    chk("nodiv_illegal", 64'(il), 64'd1);
    chk("nodiv_result", 64'(r), 64'd0);
    chk("nodiv_latency", 64'(lat), 64'd1);
    do_op(1, 3'd1, 32'h8000_0000, 32'h8000_0000, 1, r, il, lat);
    chk("r4_mulh", 64'(r), 64'h4000_0000);
    chk("r4_latency", 64'(lat), 64'd9);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      spc = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp = ref_op(f3, a, b);
      do_op(0, f3, a, b, 1, r, il, lat);
      chk($sformatf("rand_a f3=%0d a=%h b=%h", f3, a, b), 64'(r), 64'(exp));
      chk("rand_a_latency", 64'(lat), spc ? 64'd1 : 64'd33);
    end

    for (int i = 0; i < 20; i++) begin
      f3  = 3'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      exp = ref_op(f3, a, b);
      do_op(1, f3, a, b, 1, r, il, lat);
      chk($sformatf("rand_b f3=%0d a=%h b=%h", f3, a, b), 64'(r), 64'(exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
